axis_uart_tx: RTL and testbench
===============================

AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width per stream beat and UART data bits.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range is 2 or more.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of holding entries; must be a power of 2.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_data, input, DATA_W bits: byte from the upstream AXI-Stream master stage.
REQ-007 SHALL have port s_axis_valid, input, 1 bit: upstream byte valid.
REQ-008 SHALL have port s_axis_last, input, 1 bit: marks the final byte of a message.
REQ-009 SHALL have port s_axis_ready, output, 1 bit: block can accept a byte.
REQ-010 SHALL have port tx, output, 1 bit: UART serial line, 8N1, idles high.
REQ-011 SHALL have port busy, output, 1 bit: serializer is not IDLE.
REQ-012 SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of the stop bit of a byte tagged last.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

Function
REQ-014 SHALL define s_axis_ready = (fifo_level != FIFO_DEPTH), combinational from registered state, with no dependency on s_axis_valid.
REQ-015 SHALL push {s_axis_last, s_axis_data} on every edge where s_axis_valid && s_axis_ready.
REQ-016 SHALL support push and pop on the same edge; fifo_level is then unchanged.
REQ-017 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH.
REQ-018 SHALL ignore push attempts while full; the upstream holds its data, so no data is lost.
REQ-019 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-020 SHALL, in IDLE with the FIFO non-empty: pop the head, load the shift register and last flag, go to START, and drive tx low on that edge.
REQ-021 SHALL therefore drive tx low at edge N+1 when a byte is accepted at edge N into an empty FIFO while IDLE.
REQ-022 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a bit counter that is cleared on each state or bit change.
REQ-023 SHALL move START to DATA and send DATA_W bits LSB-first, then go to STOP.
REQ-024 SHALL drive tx high during STOP.
REQ-025 SHALL, at the end of STOP, pop and go directly to START if the FIFO is non-empty (no idle gap); otherwise go to IDLE.
REQ-026 SHALL make one frame exactly (DATA_W+2)*CLKS_PER_BIT cycles.
REQ-027 SHALL assert frame_done for exactly one cycle, on the final cycle of STOP, when the stored last flag is 1.
REQ-028 SHALL register tx, so it is glitch-free.

Reset
REQ-029 SHALL, on rst assertion (asynchronous, effective immediately, including mid-frame): tx=1, busy=0, frame_done=0, fifo_level=0, s_axis_ready=1, state=IDLE, all counters and pointers 0.
REQ-030 SHALL discard any partially sent frame and all FIFO contents on reset.
REQ-031 SHALL accept a push on the first rising edge after rst deasserts.

Structure
REQ-032 SHALL place in shared package axis_uart_pkg: the state enum (IDLE, START, DATA, STOP), the DATA_W default, the CLKS_PER_BIT default and the FIFO_DEPTH default.
REQ-033 SHALL implement the FIFO as one sub-module, axis_byte_fifo (synchronous, DATA_W+1 bits wide, with level output); the serializer FSM lives in the top module.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 SHALL cover a single byte 0x48: tx reads start 0, bits 0,0,0,1,0,0,1,0, stop 1, each 4 cycles; busy high for 40 cycles; fifo_level returns to 0.
REQ-035 SHALL cover "HELLO\n" (0x48,0x45,0x4C,0x4C,0x4F,0x0A) with last on 0x0A: 240 contiguous tx cycles with no idle gap, and one frame_done pulse at cycle 240 only.
REQ-036 SHALL cover 6 bytes pushed back-to-back while idle: the first pops immediately; s_axis_ready drops once fifo_level=4; the 6th byte is held until the first frame ends, then accepted; all 6 bytes appear on tx in order.
REQ-037 SHALL cover a push on the same edge as the end-of-STOP pop at fifo_level=2: fifo_level stays 2 and the next frame starts with no gap.
REQ-038 SHALL cover rst pulsed during DATA bit 3: tx=1, fifo_level=0 and s_axis_ready=1 in the same cycle; a fresh byte 0x55 is then sent correctly.
REQ-039 SHALL cover s_axis_valid held with s_axis_ready low for 10 cycles: exactly one push occurs when ready rises, with no duplicate.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared types and parameter defaults for the AXI-Stream UART transmitter.
package axis_uart_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/axis_byte_fifo.sv
// Synchronous holding FIFO with occupancy output; pushes while full and pops
// while empty are ignored.
module axis_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; the pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream to 8N1 UART transmitter: byte FIFO feeding a registered-output
// serializer that chains frames back-to-back while data is queued.
//
// state | meaning
// IDLE  | line high, waiting for FIFO data
// START | start bit (low)
// DATA  | DATA_W data bits, LSB first
// STOP  | stop bit (high); pops the next byte at its end if one is queued
module axis_uart_tx
  import axis_uart_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           s_axis_data,
  input  logic                        s_axis_valid,
  input  logic                        s_axis_last,
  output logic                        s_axis_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W:0]   head;
  logic              last_q;
  logic              tx_q;
  logic              bit_end;
  logic              last_bit;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;

  assign push     = s_axis_valid && s_axis_ready;
  assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
  assign shifted  = shreg >> 1;
  assign tx       = tx_q;

  axis_byte_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({s_axis_last, s_axis_data}),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + CNT_W'(1);
      if (pop) begin
        shreg   <= head[DATA_W-1:0];
        last_q  <= head[DATA_W];
        bit_idx <= '0;
        tx_q    <= 1'b0;
      end else begin
        case (state)
          START: if (bit_end) tx_q <= shreg[0];
          DATA: begin
            if (bit_end) begin
              if (last_bit) begin
                tx_q <= 1'b1;
              end else begin
                shreg   <= shifted;
                tx_q    <= shifted[0];
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && last_bit) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    frame_done   = (state == STOP) && bit_end && last_q;
    s_axis_ready = !fifo_full;
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: frame-level reference model predicts every output each cycle.
module tb_axis_uart_tx;

  localparam int DW    = 8;
  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = (DW + 2) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_data  = '0;
  logic       s_axis_valid = 1'b0;
  logic       s_axis_last  = 1'b0;
  logic       s_axis_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_level;

  axis_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of accepted {last,data}, current frame and its age k.
  logic [8:0] q[$];
  bit         m_busy = 1'b0;
  int         k = 0;
  logic [8:0] cur = '0;

  int mon_busy, mon_fd, mon_fd_at, mon_rise;
  bit prev_busy;

  function automatic logic exp_tx();
    int slot;
    if (!m_busy) return 1'b1;
    slot = k / C;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return cur[slot-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("tx", 32'(tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(m_busy));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("s_axis_ready", 32'(s_axis_ready), 32'(q.size() != D));
    check("frame_done", 32'(frame_done), 32'(m_busy && k == FRAME - 1 && cur[8]));
  endtask

  task automatic clear_mon();
    mon_busy = 0; mon_fd = 0; mon_fd_at = 0; mon_rise = 0; prev_busy = 1'b0;
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit l, output bit acc);
    s_axis_valid = v;
    s_axis_data  = d;
    s_axis_last  = l;
    @(posedge clk);
    acc = v && (q.size() != D);
    if (m_busy) begin
      k++;
      if (k == FRAME) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          k   = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end else if (q.size() > 0) begin
      cur    = q.pop_front();
      m_busy = 1'b1;
      k      = 0;
    end
    if (acc) q.push_back({l, d});
    #1;
    check_outputs();
    if (busy === 1'b1) begin
      mon_busy++;
      if (!prev_busy) mon_rise++;
    end
    prev_busy = (busy === 1'b1);
    if (frame_done === 1'b1) begin
      mon_fd++;
      mon_fd_at = mon_busy;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int budget, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < budget) begin
      tick(1'b1, d, l, acc);
      waited++;
    end
    s_axis_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_k(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_busy && k == target) && n < budget) begin
      idle(1);
      n++;
    end
    if (n == budget) check("wait_k_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_busy || q.size() > 0) && n < budget) begin
      idle(1);
      n++;
    end
    if (m_busy || q.size() > 0) check("drain_timeout", 32'(n), 32'(budget - 1));
    idle(2);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(s_axis_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    q.delete();
    m_busy = 1'b0;
    k      = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] hello [6];
    logic [7:0] pend_d;
    bit         pend_l, pend_v, acc;
    int         w;

    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};

    // Reset state while rst is held
    #12;
    check("init_tx", 32'(tx), 32'd1);
    check("init_busy", 32'(busy), 32'd0);
    check("init_level", 32'(fifo_level), 32'd0);
    check("init_ready", 32'(s_axis_ready), 32'd1);
    check("init_frame_done", 32'(frame_done), 32'd0);
    #8 rst = 1'b0;

    // Single byte 0x48
    clear_mon();
    send(8'h48, 1'b0, 1, w);
    idle(50);
    check("single_busy_cycles", 32'(mon_busy), 32'd40);
    check("single_no_done", 32'(mon_fd), 32'd0);
    check("single_level", 32'(fifo_level), 32'd0);

    // "HELLO\n" as one message
    clear_mon();
    for (int i = 0; i < 6; i++) send(hello[i], i == 5, 100, w);
    drain(1000);
    check("hello_busy_cycles", 32'(mon_busy), 32'd240);
    check("hello_contiguous", 32'(mon_rise), 32'd1);
    check("hello_done_count", 32'(mon_fd), 32'd1);
    check("hello_done_cycle", 32'(mon_fd_at), 32'd240);

    // Six back-to-back bytes: FIFO fills, sixth held until first frame ends
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1, w);
    check("fill_level4", 32'(fifo_level), 32'd4);
    check("fill_ready_low", 32'(s_axis_ready), 32'd0);
    send(8'hC3, 1'b1, 100, w);
    check("sixth_wait_long", 32'(w > 30), 32'd1);
    drain(1000);

    // Push on the same edge as the end-of-stop pop at level 2
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1, w);
    check("pre_same_edge_level", 32'(fifo_level), 32'd2);
    wait_k(FRAME - 1, 100);
    tick(1'b1, 8'h5A, 1'b0, acc);
    check("same_edge_accept", 32'(acc), 32'd1);
    check("same_edge_level", 32'(fifo_level), 32'd2);
    check("same_edge_no_gap", 32'(tx), 32'd0);
    drain(1000);

    // Reset during data bit 3, then a fresh 0x55 on the first edge after release
    send(8'hA5, 1'b0, 1, w);
    send(8'h3C, 1'b1, 1, w);
    wait_k(C + 3 * C + 1, 100);
    pulse_rst();
    clear_mon();
    send(8'h55, 1'b1, 1, w);
    drain(1000);
    check("post_rst_busy", 32'(mon_busy), 32'd40);
    check("post_rst_done", 32'(mon_fd), 32'd1);

    // Valid held against a full FIFO: exactly one acceptance
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1, w);
    send(8'h3C, 1'b0, 100, w);
    check("held_cycles", 32'(w > 10), 32'd1);
    drain(1000);

    // Random traffic with valid held until accepted
    pend_v = 1'b0; pend_d = '0; pend_l = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend_v && ($urandom_range(0, 3) == 0)) begin
        pend_v = 1'b1;
        pend_d = 8'($urandom);
        pend_l = ($urandom_range(0, 2) == 0);
      end
      tick(pend_v, pend_d, pend_l, acc);
      if (acc) pend_v = 1'b0;
    end
    s_axis_valid = 1'b0;
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
